// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Also carries the saturating increment used by the HAZARD_PERF_EN counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int REG_ZERO = 0;
    localparam int PERF_W   = 32;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding select for one E-stage source operand: M beats W, x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] rs_e_i,
    input  logic [W-1:0] rd_m_i,
    input  logic [W-1:0] rd_w_i,
    input  logic         reg_write_m_i,
    input  logic         reg_write_w_i,
    output fwd_sel_t     fwd_o
);

    localparam logic [W-1:0] RZ = W'(REG_ZERO);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != RZ) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != RZ) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the F/D/E/M/W core with a multi-cycle data-memory wait FSM.
// Optional HAZARD_PERF_EN adds saturating load-use / flush / mem-wait event counters.
//   state    | meaning
//   IDLE     | normal flow: load-use stall and branch flush handling
//   MEM_WAIT | M access in progress: freeze F..M, bubble into W
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] RsD_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] RsE_i,
    input  logic [REG_ADDR_WIDTH-1:0]         RdE_i,
    input  logic [REG_ADDR_WIDTH-1:0]         RdM_i,
    input  logic [REG_ADDR_WIDTH-1:0]         RdW_i,
    input  logic                              RegWriteM_i,
    input  logic                              RegWriteW_i,
    input  logic                              LoadE_i,
    input  logic                              MemReqM_i,
    input  logic                              PCSrcE_i,
    output logic [NUM_SRC*2-1:0]              ForwardE_o,
    output logic                              StallF_o,
    output logic                              StallD_o,
    output logic                              StallE_o,
    output logic                              StallM_o,
    output logic                              FlushD_o,
    output logic                              FlushE_o,
    output logic                              FlushW_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]                 LoadUseCnt_o,
    output logic [PERF_W-1:0]                 FlushCnt_o,
    output logic [PERF_W-1:0]                 MemWaitCnt_o
`endif
);

    localparam bit                        WAIT_EN  = (MEM_LATENCY > 1);
    localparam logic [3:0]                CNT_LOAD = 4'(MEM_LATENCY - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] RZ       = REG_ADDR_WIDTH'(REG_ZERO);

    fwd_sel_t  fwd_w [NUM_SRC];
    hz_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wait_active;
    logic       src_hit;
    logic       lw_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        fwd_sel #(.W(REG_ADDR_WIDTH)) u_fwd_sel (
            .rs_e_i        (RsE_i[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .rd_m_i        (RdM_i),
            .rd_w_i        (RdW_i),
            .reg_write_m_i (RegWriteM_i),
            .reg_write_w_i (RegWriteW_i),
            .fwd_o         (fwd_w[g])
        );
        assign ForwardE_o[g*2 +: 2] = fwd_w[g];
    end

    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (RsD_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == RdE_i) src_hit = 1'b1;
        end
    end

    assign lw_stall = LoadE_i && (RdE_i != RZ) && src_hit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The cnt==1 cycle is the release cycle: M completes and outputs follow IDLE rules.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_active = 1'b0;
        case (state_q)
            IDLE: begin
                if (WAIT_EN && MemReqM_i) begin
                    state_d     = MEM_WAIT;
                    cnt_d       = CNT_LOAD;
                    wait_active = 1'b1;
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end else begin
                    wait_active = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        FlushW_o = 1'b0;
        if (!rst_i) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
            FlushW_o = 1'b1;
        end else if (wait_active) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
        end else begin
            StallF_o = lw_stall;
            StallD_o = lw_stall;
            FlushE_o = lw_stall | PCSrcE_i;
            FlushD_o = PCSrcE_i;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] load_use_cnt_q, flush_cnt_q, mem_wait_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            load_use_cnt_q <= sat_inc(load_use_cnt_q, !wait_active && lw_stall);
            flush_cnt_q    <= sat_inc(flush_cnt_q, !wait_active && PCSrcE_i);
            mem_wait_cnt_q <= sat_inc(mem_wait_cnt_q, wait_active);
        end
    end

    assign LoadUseCnt_o = load_use_cnt_q;
    assign FlushCnt_o   = flush_cnt_q;
    assign MemWaitCnt_o = mem_wait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (MEM_LATENCY 1 and 3) against a cycle-level reference model.
module tb_hazard_unit;

    localparam int NS = 2;
    localparam int W  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NS*W-1:0] rsd, rse;
    logic [W-1:0]    rde, rdm, rdw;
    logic            rwm, rww, loade, memreq, pcsrc;

    wire [NS*2-1:0] fwd_a, fwd_b;
    wire [6:0]      ctl_a, ctl_b;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
`ifdef HAZARD_PERF_EN
    wire [31:0] luc_a, flc_a, mwc_a, luc_b, flc_b, mwc_b;
`endif

    hazard_unit #(.NUM_SRC(NS), .REG_ADDR_WIDTH(W), .MEM_LATENCY(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .RsD_i(rsd), .RsE_i(rse),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .RegWriteM_i(rwm), .RegWriteW_i(rww), .LoadE_i(loade),
        .MemReqM_i(memreq), .PCSrcE_i(pcsrc), .ForwardE_o(fwd_a),
        .StallF_o(ctl_a[6]), .StallD_o(ctl_a[5]), .StallE_o(ctl_a[4]), .StallM_o(ctl_a[3]),
        .FlushD_o(ctl_a[2]), .FlushE_o(ctl_a[1]), .FlushW_o(ctl_a[0])
`ifdef HAZARD_PERF_EN
        , .LoadUseCnt_o(luc_a), .FlushCnt_o(flc_a), .MemWaitCnt_o(mwc_a)
`endif
    );

    hazard_unit #(.NUM_SRC(NS), .REG_ADDR_WIDTH(W), .MEM_LATENCY(3)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .RsD_i(rsd), .RsE_i(rse),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .RegWriteM_i(rwm), .RegWriteW_i(rww), .LoadE_i(loade),
        .MemReqM_i(memreq), .PCSrcE_i(pcsrc), .ForwardE_o(fwd_b),
        .StallF_o(ctl_b[6]), .StallD_o(ctl_b[5]), .StallE_o(ctl_b[4]), .StallM_o(ctl_b[3]),
        .FlushD_o(ctl_b[2]), .FlushE_o(ctl_b[1]), .FlushW_o(ctl_b[0])
`ifdef HAZARD_PERF_EN
        , .LoadUseCnt_o(luc_b), .FlushCnt_o(flc_b), .MemWaitCnt_o(mwc_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model state per instance: remaining frozen cycles, pending release cycle, event tallies.
    int          lat [2] = '{1, 3};
    int          stall_left [2] = '{0, 0};
    bit          rel [2] = '{0, 0};
    int unsigned lu_n [2] = '{0, 0};
    int unsigned fl_n [2] = '{0, 0};
    int unsigned mw_n [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [W-1:0] rs);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Compares both instances against the model for the current inputs, then advances
    // the model to the state it will hold after the next rising edge.
    task automatic check_now(input string tag);
        logic [6:0]      exp_ctl;
        logic [NS*2-1:0] exp_fwd;
        bit              w, lw;
        lw = 1'b0;
        if (loade && rde != 0)
            for (int k = 0; k < NS; k++) if (rsd[k*W +: W] == rde) lw = 1'b1;
        for (int k = 0; k < NS; k++) exp_fwd[k*2 +: 2] = ref_fwd(rse[k*W +: W]);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                stall_left[d] = 0; rel[d] = 1'b0;
                lu_n[d] = 0; fl_n[d] = 0; mw_n[d] = 0;
                exp_ctl = 7'b0000111;
            end else begin
                if (stall_left[d] > 0) begin
                    w = 1'b1;
                    stall_left[d]--;
                    if (stall_left[d] == 0) rel[d] = 1'b1;
                end else if (rel[d]) begin
                    w = 1'b0;
                    rel[d] = 1'b0;
                end else if (memreq && lat[d] > 1) begin
                    w = 1'b1;
                    stall_left[d] = lat[d] - 2;
                    if (stall_left[d] == 0) rel[d] = 1'b1;
                end else begin
                    w = 1'b0;
                end
                exp_ctl = w ? 7'b1111001 : {lw, lw, 2'b00, pcsrc, lw | pcsrc, 1'b0};
                if (w) mw_n[d]++;
                if (!w && lw) lu_n[d]++;
                if (!w && pcsrc) fl_n[d]++;
            end
            chk($sformatf("%s_ctl%0d", tag, d), 32'(d == 0 ? ctl_a : ctl_b), 32'(exp_ctl));
            chk($sformatf("%s_fwd%0d", tag, d), 32'(d == 0 ? fwd_a : fwd_b), 32'(exp_fwd));
        end
    endtask

    task automatic clear_inputs();
        rsd = '0; rse = '0; rde = '0; rdm = '0; rdw = '0;
        rwm = 1'b0; rww = 1'b0; loade = 1'b0; memreq = 1'b0; pcsrc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #1 check_now("reset");
        chk("reset_ctl_b", 32'(ctl_b), 32'h07);
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding: M has priority, x0 in M falls back to W.
        rse = {5'd3, 5'd3}; rdm = 5'd3; rwm = 1'b1; rdw = 5'd3; rww = 1'b1;
        #1 check_now("fwd_m");
        chk("fwd_m_const", 32'(fwd_a), 32'hA);
        @(negedge clk);
        rdm = 5'd0;
        #1 check_now("fwd_w");
        chk("fwd_w_const", 32'(fwd_a), 32'h5);
        @(negedge clk);
        clear_inputs();

        // Load-use on source 1, then the same with RdE = x0.
        loade = 1'b1; rde = 5'd5; rsd = {5'd5, 5'd0};
        #1 check_now("lduse");
        chk("lduse_const", 32'(ctl_a), 32'h62);
        @(negedge clk);
        rde = 5'd0;
        #1 check_now("lduse_x0");
        chk("lduse_x0_const", 32'(ctl_a), 32'h00);
        @(negedge clk);
        clear_inputs();

        // Branch alone, then branch with load-use.
        pcsrc = 1'b1;
        #1 check_now("branch");
        chk("branch_const", 32'(ctl_a), 32'h06);
        @(negedge clk);
        loade = 1'b1; rde = 5'd7; rsd = {5'd0, 5'd7};
        #1 check_now("branch_lw");
        chk("branch_lw_const", 32'(ctl_a), 32'h66);
        @(negedge clk);
        clear_inputs();

        // Three-cycle memory access with a branch held in E during the wait.
        memreq = 1'b1; pcsrc = 1'b1;
        #1 check_now("mw0");
        chk("mw0_const", 32'(ctl_b), 32'h79);
        @(negedge clk);
        #1 check_now("mw1");
        chk("mw1_const", 32'(ctl_b), 32'h79);
        @(negedge clk);
        #1 check_now("mw_rel");
        chk("mw_rel_const", 32'(ctl_b), 32'h06);
        @(negedge clk);
        clear_inputs();
        #1 check_now("mw_idle");
        chk("mw_idle_const", 32'(ctl_b), 32'h00);
        @(negedge clk);

        // Asynchronous reset in the second wait cycle, between clock edges.
        memreq = 1'b1;
        #1 check_now("rw0");
        @(negedge clk);
        memreq = 1'b0;
        #1 check_now("rw1");
        chk("rw1_const", 32'(ctl_b), 32'h79);
        #2 rst_n = 1'b0;
        #1 check_now("async_rst");
        chk("async_rst_const", 32'(ctl_b), 32'h07);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_now("post_rst");
        chk("post_rst_const", 32'(ctl_b), 32'h00);
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NS; k++) begin
                rsd[k*W +: W] = W'($urandom_range(0, 3));
                rse[k*W +: W] = W'($urandom_range(0, 3));
            end
            rde    = W'($urandom_range(0, 3));
            rdm    = W'($urandom_range(0, 3));
            rdw    = W'($urandom_range(0, 3));
            rwm    = 1'($urandom_range(0, 1));
            rww    = 1'($urandom_range(0, 1));
            loade  = ($urandom_range(0, 2) == 0);
            memreq = ($urandom_range(0, 5) == 0);
            pcsrc  = ($urandom_range(0, 4) == 0);
            #1 check_now("rnd");
            @(negedge clk);
        end
        clear_inputs();

`ifdef HAZARD_PERF_EN
        #1;
        chk("lu_cnt_a", luc_a, lu_n[0]);
        chk("fl_cnt_a", flc_a, fl_n[0]);
        chk("mw_cnt_a", mwc_a, mw_n[0]);
        chk("lu_cnt_b", luc_b, lu_n[1]);
        chk("fl_cnt_b", flc_b, fl_n[1]);
        chk("mw_cnt_b", mwc_b, mw_n[1]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
